// File: rtl/mem_bus_router_pkg.sv
// Shared constants and FSM encoding for the CPU-side memory router and its MMIO bank.
package mem_bus_router_pkg;

   localparam logic [3:0]  REGION_RAM       = 4'h0;
   localparam logic [3:0]  REGION_MMIO      = 4'h1;

   localparam logic [1:0]  OFF_LED          = 2'd0;
   localparam logic [1:0]  OFF_CYCLE        = 2'd1;
   localparam logic [1:0]  OFF_STATUS       = 2'd2;

   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_BRAM_WAIT = 2'd1,
      ST_DONE      = 2'd2
   } state_e;

endpackage

// File: rtl/mem_bus_router_mmio_regs.sv
// Local MMIO bank: LED register, free-running cycle counter, sticky bus error and read mux.
module mmio_regs
   import mem_bus_router_pkg::*;
(
   input  logic        clk,
   input  logic        nrst,
   input  logic        acc_en,
   input  logic        acc_write,
   input  logic [1:0]  acc_off,
   input  logic [7:0]  acc_wdata,
   input  logic        acc_strb0,
   input  logic        set_err,
   output logic [7:0]  leds,
   output logic        bus_err,
   output logic [31:0] rd_data
);

   logic [7:0]  leds_q, leds_d;
   logic [31:0] cycle_q, cycle_d;
   logic        err_q, err_d;
   logic        wr_lane0;

   always_comb begin
      wr_lane0 = acc_en && acc_write && acc_strb0;
      leds_d   = leds_q;
      cycle_d  = cycle_q + 32'd1;
      err_d    = err_q;
      if (wr_lane0 && (acc_off == OFF_LED)) begin
         leds_d = acc_wdata;
      end
      if (wr_lane0 && (acc_off == OFF_STATUS) && acc_wdata[0]) begin
         err_d = 1'b0;
      end
      // A new error in the same cycle as a software clear must not be lost.
      if (set_err) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         leds_q  <= 8'd0;
         cycle_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         leds_q  <= leds_d;
         cycle_q <= cycle_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      rd_data = 32'd0;
      case (acc_off)
         OFF_LED:    rd_data = {24'd0, leds_q};
         OFF_CYCLE:  rd_data = cycle_q;
         OFF_STATUS: rd_data = {31'd0, err_q};
         default:    rd_data = 32'd0;
      endcase
   end

   assign leds    = leds_q;
   assign bus_err = err_q;

endmodule

// File: rtl/mem_bus_router.sv
// Routes picorv32 native memory requests to block RAM, the local MMIO bank, or an error reply.
module mem_bus_router
   import mem_bus_router_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   output logic        bram_valid,
   input  logic        bram_ready,
   output logic [31:0] bram_addr,
   output logic [31:0] bram_wdata,
   output logic [3:0]  bram_wstrb,
   input  logic [31:0] bram_rdata,
   output logic [7:0]  leds,
   output logic        bus_err
);

   localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_e        state_q, state_d;
   logic          mem_ready_q, mem_ready_d;
   logic [31:0]   mem_rdata_q, mem_rdata_d;
   logic          bram_valid_q, bram_valid_d;
   logic [31:0]   bram_addr_q, bram_addr_d;
   logic [31:0]   bram_wdata_q, bram_wdata_d;
   logic [3:0]    bram_wstrb_q, bram_wstrb_d;
   logic [TW-1:0] tmo_q, tmo_d;

   logic [3:0]    region;
   logic          is_write;
   logic          timeout_hit;
   logic          mmio_en;
   logic          set_err;
   logic [31:0]   mmio_rdata;

   assign region      = mem_addr[31:28];
   assign is_write    = |mem_wstrb;
   assign timeout_hit = (tmo_q == TMO_LAST);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (mem_valid) begin
               state_d = (region == REGION_RAM) ? ST_BRAM_WAIT : ST_DONE;
            end
         end
         ST_BRAM_WAIT: begin
            if (bram_ready || timeout_hit) begin
               state_d = ST_DONE;
            end
         end
         // Leaving only once ready is low keeps a held-over ready from answering the next request.
         ST_DONE: begin
            if (!bram_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_ready_d  = 1'b0;
      mem_rdata_d  = mem_rdata_q;
      bram_valid_d = bram_valid_q;
      bram_addr_d  = bram_addr_q;
      bram_wdata_d = bram_wdata_q;
      bram_wstrb_d = bram_wstrb_q;
      tmo_d        = tmo_q;
      mmio_en      = 1'b0;
      set_err      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mem_valid) begin
               if (region == REGION_RAM) begin
                  bram_valid_d = 1'b1;
                  bram_addr_d  = mem_addr;
                  bram_wdata_d = mem_wdata;
                  bram_wstrb_d = mem_wstrb;
                  tmo_d        = '0;
               end else if (region == REGION_MMIO) begin
                  mmio_en     = 1'b1;
                  mem_rdata_d = is_write ? 32'd0 : mmio_rdata;
                  mem_ready_d = 1'b1;
               end else begin
                  mem_rdata_d = ERR_DATA;
                  mem_ready_d = 1'b1;
                  set_err     = 1'b1;
               end
            end
         end
         ST_BRAM_WAIT: begin
            if (bram_ready) begin
               bram_valid_d = 1'b0;
               mem_rdata_d  = bram_rdata;
               mem_ready_d  = 1'b1;
            end else if (timeout_hit) begin
               bram_valid_d = 1'b0;
               mem_rdata_d  = ERR_DATA;
               mem_ready_d  = 1'b1;
               set_err      = 1'b1;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         mem_ready_q  <= 1'b0;
         mem_rdata_q  <= 32'd0;
         bram_valid_q <= 1'b0;
         bram_addr_q  <= 32'd0;
         bram_wdata_q <= 32'd0;
         bram_wstrb_q <= 4'd0;
         tmo_q        <= '0;
      end else begin
         mem_ready_q  <= mem_ready_d;
         mem_rdata_q  <= mem_rdata_d;
         bram_valid_q <= bram_valid_d;
         bram_addr_q  <= bram_addr_d;
         bram_wdata_q <= bram_wdata_d;
         bram_wstrb_q <= bram_wstrb_d;
         tmo_q        <= tmo_d;
      end
   end

   mmio_regs u_mmio (
      .clk       (clk),
      .nrst      (nrst),
      .acc_en    (mmio_en),
      .acc_write (is_write),
      .acc_off   (mem_addr[3:2]),
      .acc_wdata (mem_wdata[7:0]),
      .acc_strb0 (mem_wstrb[0]),
      .set_err   (set_err),
      .leds      (leds),
      .bus_err   (bus_err),
      .rd_data   (mmio_rdata)
   );

   assign mem_ready  = mem_ready_q;
   assign mem_rdata  = mem_rdata_q;
   assign bram_valid = bram_valid_q;
   assign bram_addr  = bram_addr_q;
   assign bram_wdata = bram_wdata_q;
   assign bram_wstrb = bram_wstrb_q;

endmodule

// File: tb/tb_mem_bus_router.sv
// Bench for mem_bus_router: CPU driver, block-RAM controller model and a reference model of the address map.
module tb_mem_bus_router;

   logic        clk;
   logic        nrst;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        bram_valid;
   logic        bram_ready;
   logic [31:0] bram_addr;
   logic [31:0] bram_wdata;
   logic [3:0]  bram_wstrb;
   logic [31:0] bram_rdata;
   logic [7:0]  leds;
   logic        bus_err;

   int vectors = 0;
   int errors  = 0;

   logic [31:0] bram_mem [0:255];
   logic [31:0] ref_mem  [0:255];
   logic [7:0]  ref_leds;
   logic        ref_err;
   logic [31:0] exp_q [$];

   bit          ram_respond;
   int          ram_hold;
   int          hold_left;
   logic        v_cap;
   int unsigned edge_cnt;

   mem_bus_router dut (
      .clk        (clk),
      .nrst       (nrst),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_rdata  (mem_rdata),
      .bram_valid (bram_valid),
      .bram_ready (bram_ready),
      .bram_addr  (bram_addr),
      .bram_wdata (bram_wdata),
      .bram_wstrb (bram_wstrb),
      .bram_rdata (bram_rdata),
      .leds       (leds),
      .bus_err    (bus_err)
   );

   // clock / reset / edge bookkeeping
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge nrst) begin
      if (!nrst) edge_cnt = 0;
      else       edge_cnt = edge_cnt + 1;
   end

   // RAM controller model: registered response one cycle after it sees bram_valid
   always @(negedge clk) v_cap = bram_valid;

   always begin
      @(posedge clk);
      #1;
      if (!nrst) begin
         bram_ready = 1'b0;
      end else if (bram_ready) begin
         if (hold_left > 0) hold_left = hold_left - 1;
         else               bram_ready = 1'b0;
      end else if (v_cap && ram_respond) begin
         if (bram_wstrb == 4'd0) begin
            bram_rdata = bram_mem[bram_addr[9:2]];
         end else begin
            for (int b = 0; b < 4; b++)
               if (bram_wstrb[b]) bram_mem[bram_addr[9:2]][8*b +: 8] = bram_wdata[8*b +: 8];
            bram_rdata = 32'd0;
         end
         bram_ready = 1'b1;
         hold_left  = ram_hold;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required finish before 500000");
      errors = errors + 1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic apply_reset();
      nrst = 1'b0;
      mem_valid = 1'b0;
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      ref_leds = 8'd0;
      ref_err  = 1'b0;
   endtask

   task automatic cpu_access(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, output logic [31:0] rdata,
                             output int lat, output int bv_cycles, output bit stable_ok,
                             output int unsigned e0);
      bit got;
      got = 1'b0;
      lat = 0;
      bv_cycles = 0;
      stable_ok = 1'b1;
      rdata = 32'hx;
      @(negedge clk);
      mem_valid = 1'b1;
      mem_addr  = addr;
      mem_wdata = wdata;
      mem_wstrb = wstrb;
      e0 = edge_cnt;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         lat = lat + 1;
         if (bram_valid) begin
            bv_cycles = bv_cycles + 1;
            if (bram_addr !== addr || bram_wdata !== wdata || bram_wstrb !== wstrb) stable_ok = 1'b0;
         end
         if (mem_ready) begin
            got = 1'b1;
            rdata = mem_rdata;
         end
      end
      mem_valid = 1'b0;
      vectors = vectors + 1;
      if (!got) begin
         errors = errors + 1;
         $display("FAIL response_wait addr=%h: no mem_ready, required within 100 cycles", addr);
      end
   endtask

   function automatic void ref_ram_write(input logic [7:0] idx, input logic [31:0] wdata,
                                         input logic [3:0] wstrb);
      for (int b = 0; b < 4; b++)
         if (wstrb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
   endfunction

   // scenarios
   task automatic test_reset();
      apply_reset();
      vectors = vectors + 1;
      if ({mem_ready, mem_rdata, bram_valid, bram_addr, bram_wdata, bram_wstrb} !== 102'd0) begin
         errors = errors + 1;
         $display("FAIL reset_bus ready=%b rdata=%h bvalid=%b baddr=%h bwdata=%h bwstrb=%h, required all 0",
                  mem_ready, mem_rdata, bram_valid, bram_addr, bram_wdata, bram_wstrb);
      end
      vectors = vectors + 1;
      if (leds !== 8'd0 || bus_err !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL reset_regs leds=%h bus_err=%b, required 00/0", leds, bus_err);
      end
   endtask

   task automatic test_ram_read();
      logic [31:0] rd; int lat; int bv; bit st; int unsigned e0;
      bram_mem[1] = 32'h1234_5678;
      ref_mem[1]  = 32'h1234_5678;
      cpu_access(32'h0000_0004, 32'd0, 4'd0, rd, lat, bv, st, e0);
      vectors = vectors + 1;
      if (rd !== 32'h1234_5678) begin
         errors = errors + 1;
         $display("FAIL ram_read_data got=%h required=12345678", rd);
      end
      vectors = vectors + 1;
      if (lat !== 3) begin
         errors = errors + 1;
         $display("FAIL ram_read_latency got=%0d required=3", lat);
      end
      vectors = vectors + 1;
      if (bv !== 2 || !st) begin
         errors = errors + 1;
         $display("FAIL ram_read_bram_valid cycles=%0d stable=%b required 2/1", bv, st);
      end
      @(negedge clk);
      vectors = vectors + 1;
      if (mem_ready !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL ram_read_pulse mem_ready=%b one cycle later, required 0", mem_ready);
      end
   endtask

   task automatic test_mmio_led();
      logic [31:0] rd; int lat; int bv; bit st; int unsigned e0;
      cpu_access(32'h1000_0000, 32'h0000_00A5, 4'b0001, rd, lat, bv, st, e0);
      ref_leds = 8'hA5;
      vectors = vectors + 1;
      if (leds !== 8'hA5 || rd !== 32'd0 || lat !== 1) begin
         errors = errors + 1;
         $display("FAIL led_write leds=%h rdata=%h lat=%0d required A5/0/1", leds, rd, lat);
      end
      cpu_access(32'h1000_0000, 32'd0, 4'd0, rd, lat, bv, st, e0);
      vectors = vectors + 1;
      if (rd !== 32'h0000_00A5 || lat !== 1) begin
         errors = errors + 1;
         $display("FAIL led_read rdata=%h lat=%0d required 000000A5/1", rd, lat);
      end
      cpu_access(32'h1000_0000, 32'h0000_5A5A, 4'b0010, rd, lat, bv, st, e0);
      vectors = vectors + 1;
      if (leds !== 8'hA5) begin
         errors = errors + 1;
         $display("FAIL led_lane1_write leds=%h required A5", leds);
      end
   endtask

   task automatic test_cycle_counter();
      logic [31:0] v1, v2; int lat; int bv; bit st; int unsigned e1, e2;
      cpu_access(32'h1000_0004, 32'd0, 4'd0, v1, lat, bv, st, e1);
      while (edge_cnt < e1 + 9) @(negedge clk);
      cpu_access(32'h1000_0004, 32'hFFFF_FFFF, 4'd0, v2, lat, bv, st, e2);
      vectors = vectors + 1;
      if (v1 !== e1) begin
         errors = errors + 1;
         $display("FAIL cycle_abs got=%0d required=%0d", v1, e1);
      end
      vectors = vectors + 1;
      if (v2 - v1 !== 32'(e2 - e1) || e2 - e1 != 10) begin
         errors = errors + 1;
         $display("FAIL cycle_delta got=%0d required=10 (edge gap %0d)", v2 - v1, e2 - e1);
      end
      cpu_access(32'h1000_0004, 32'h0000_00FF, 4'hF, v1, lat, bv, st, e1);
      vectors = vectors + 1;
      if (v1 !== 32'd0 || leds !== ref_leds) begin
         errors = errors + 1;
         $display("FAIL cycle_write rdata=%h leds=%h required 0/%h", v1, leds, ref_leds);
      end
   endtask

   task automatic test_unmapped_status();
      logic [31:0] rd; int lat; int bv; bit st; int unsigned e0;
      cpu_access(32'h2000_0000, 32'd0, 4'd0, rd, lat, bv, st, e0);
      vectors = vectors + 1;
      if (rd !== 32'hDEAD_BEEF || bus_err !== 1'b1 || lat !== 1) begin
         errors = errors + 1;
         $display("FAIL unmapped_read rdata=%h bus_err=%b lat=%0d required DEADBEEF/1/1", rd, bus_err, lat);
      end
      cpu_access(32'h1000_0008, 32'd0, 4'd0, rd, lat, bv, st, e0);
      vectors = vectors + 1;
      if (rd !== 32'd1) begin
         errors = errors + 1;
         $display("FAIL status_read_set rdata=%h required 00000001", rd);
      end
      cpu_access(32'h1000_0008, 32'd1, 4'b0001, rd, lat, bv, st, e0);
      cpu_access(32'h1000_0008, 32'd0, 4'd0, rd, lat, bv, st, e0);
      vectors = vectors + 1;
      if (rd !== 32'd0 || bus_err !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL status_clear rdata=%h bus_err=%b required 0/0", rd, bus_err);
      end
      cpu_access(32'hF000_0000, 32'h0000_0077, 4'hF, rd, lat, bv, st, e0);
      vectors = vectors + 1;
      if (rd !== 32'hDEAD_BEEF || leds !== ref_leds || bus_err !== 1'b1 || bv !== 0) begin
         errors = errors + 1;
         $display("FAIL unmapped_write rdata=%h leds=%h bus_err=%b bram_cycles=%0d required DEADBEEF/%h/1/0",
                  rd, leds, bus_err, bv, ref_leds);
      end
      cpu_access(32'h1000_000C, 32'd0, 4'd0, rd, lat, bv, st, e0);
      vectors = vectors + 1;
      if (rd !== 32'd0 || bus_err !== 1'b1) begin
         errors = errors + 1;
         $display("FAIL offset_c_read rdata=%h bus_err=%b required 0/1", rd, bus_err);
      end
      cpu_access(32'h1000_0008, 32'd1, 4'b0001, rd, lat, bv, st, e0);
   endtask

   task automatic test_timeout();
      logic [31:0] rd; int lat; int bv; bit st; int unsigned e0;
      ram_respond = 1'b0;
      cpu_access(32'h0000_0010, 32'd0, 4'd0, rd, lat, bv, st, e0);
      ram_respond = 1'b1;
      vectors = vectors + 1;
      if (bv !== 16 || lat !== 17) begin
         errors = errors + 1;
         $display("FAIL timeout_timing bram_cycles=%0d lat=%0d required 16/17", bv, lat);
      end
      vectors = vectors + 1;
      if (rd !== 32'hDEAD_BEEF || bus_err !== 1'b1) begin
         errors = errors + 1;
         $display("FAIL timeout_resp rdata=%h bus_err=%b required DEADBEEF/1", rd, bus_err);
      end
      cpu_access(32'h1000_0008, 32'd1, 4'b0001, rd, lat, bv, st, e0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; int lat; int bv; bit st; int unsigned e0;
      int holds [2];
      holds[0] = 1;
      holds[1] = 3;
      for (int h = 0; h < 2; h++) begin
         ram_hold = holds[h];
         bram_mem[2] = 32'h1111_2222 + 32'(h); ref_mem[2] = bram_mem[2];
         bram_mem[3] = 32'h3333_4444 + 32'(h); ref_mem[3] = bram_mem[3];
         cpu_access(32'h0000_0008, 32'd0, 4'd0, rd, lat, bv, st, e0);
         vectors = vectors + 1;
         if (rd !== ref_mem[2]) begin
            errors = errors + 1;
            $display("FAIL b2b_first hold=%0d rdata=%h required=%h", ram_hold, rd, ref_mem[2]);
         end
         cpu_access(32'h0000_000C, 32'd0, 4'd0, rd, lat, bv, st, e0);
         vectors = vectors + 1;
         if (rd !== ref_mem[3] || !st) begin
            errors = errors + 1;
            $display("FAIL b2b_second hold=%0d rdata=%h stable=%b required=%h/1", ram_hold, rd, st, ref_mem[3]);
         end
      end
      ram_hold = 0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_random();
      logic [31:0] rd, addr, wdata, exp; logic [3:0] wstrb; logic [7:0] idx;
      logic [1:0] off; int kind; int exp_lat; int lat; int bv; bit st; int unsigned e0;
      apply_reset();
      ram_respond = 1'b1;
      ram_hold = 0;
      for (int n = 0; n < 80; n++) begin
         kind  = $urandom_range(0, 9);
         wdata = $urandom;
         if (kind <= 4) begin
            idx   = 8'($urandom_range(0, 255));
            addr  = {22'd0, idx, 2'b00};
            wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
            exp_lat = 3;
         end else if (kind <= 7) begin
            off   = 2'($urandom_range(0, 3));
            addr  = 32'h1000_0000 + {28'd0, off, 2'b00};
            wstrb = 4'($urandom_range(0, 15));
            exp_lat = 1;
         end else begin
            addr  = {4'($urandom_range(2, 15)), 28'($urandom)};
            wstrb = 4'($urandom_range(0, 15));
            exp_lat = 1;
         end
         cpu_access(addr, wdata, wstrb, rd, lat, bv, st, e0);
         // reference model of the address map
         if (addr[31:28] == 4'h0) begin
            idx = addr[9:2];
            if (wstrb != 4'd0) begin
               ref_ram_write(idx, wdata, wstrb);
               exp_q.push_back(32'd0);
            end else begin
               exp_q.push_back(ref_mem[idx]);
            end
         end else if (addr[31:28] == 4'h1) begin
            if (wstrb != 4'd0) begin
               exp_q.push_back(32'd0);
               if (wstrb[0] && addr[3:2] == 2'd0) ref_leds = wdata[7:0];
               if (wstrb[0] && addr[3:2] == 2'd2 && wdata[0]) ref_err = 1'b0;
            end else begin
               case (addr[3:2])
                  2'd0:    exp_q.push_back({24'd0, ref_leds});
                  2'd1:    exp_q.push_back(32'(e0));
                  2'd2:    exp_q.push_back({31'd0, ref_err});
                  default: exp_q.push_back(32'd0);
               endcase
            end
         end else begin
            exp_q.push_back(32'hDEAD_BEEF);
            ref_err = 1'b1;
         end
         exp = exp_q.pop_front();
         vectors = vectors + 1;
         if (rd !== exp || lat !== exp_lat) begin
            errors = errors + 1;
            $display("FAIL rand_resp n=%0d addr=%h wstrb=%h rdata=%h lat=%0d required %h/%0d",
                     n, addr, wstrb, rd, lat, exp, exp_lat);
         end
         vectors = vectors + 1;
         if (leds !== ref_leds || bus_err !== ref_err || !st) begin
            errors = errors + 1;
            $display("FAIL rand_state n=%0d leds=%h bus_err=%b stable=%b required %h/%b/1",
                     n, leds, bus_err, st, ref_leds, ref_err);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; int lat; int bv; bit st; int unsigned e0; bit saw_ready;
      cpu_access(32'h1000_0000, 32'h0000_003C, 4'b0001, rd, lat, bv, st, e0);
      ram_respond = 1'b0;
      @(negedge clk);
      mem_valid = 1'b1;
      mem_addr  = 32'h0000_0020;
      mem_wdata = 32'd0;
      mem_wstrb = 4'd0;
      repeat (5) @(negedge clk);
      vectors = vectors + 1;
      if (bram_valid !== 1'b1 || leds !== 8'h3C) begin
         errors = errors + 1;
         $display("FAIL mid_pre bram_valid=%b leds=%h required 1/3C", bram_valid, leds);
      end
      #2;
      nrst = 1'b0;
      #1;
      vectors = vectors + 1;
      if (bram_valid !== 1'b0 || mem_ready !== 1'b0 || leds !== 8'd0) begin
         errors = errors + 1;
         $display("FAIL mid_reset bram_valid=%b mem_ready=%b leds=%h required 0/0/00", bram_valid, mem_ready, leds);
      end
      @(negedge clk);
      mem_valid = 1'b0;
      @(negedge clk);
      nrst = 1'b1;
      ref_leds = 8'd0;
      ref_err  = 1'b0;
      ram_respond = 1'b1;
      saw_ready = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (mem_ready || bram_valid) saw_ready = 1'b1;
      end
      vectors = vectors + 1;
      if (saw_ready) begin
         errors = errors + 1;
         $display("FAIL mid_no_response activity seen after reset, required none");
      end
      cpu_access(32'h1000_0000, 32'd0, 4'd0, rd, lat, bv, st, e0);
      vectors = vectors + 1;
      if (rd !== 32'd0 || lat !== 1) begin
         errors = errors + 1;
         $display("FAIL mid_recover rdata=%h lat=%0d required 0/1", rd, lat);
      end
   endtask

   initial begin
      nrst       = 1'b0;
      mem_valid  = 1'b0;
      mem_addr   = 32'd0;
      mem_wdata  = 32'd0;
      mem_wstrb  = 4'd0;
      bram_ready = 1'b0;
      bram_rdata = 32'd0;
      ram_respond = 1'b1;
      ram_hold   = 0;
      hold_left  = 0;
      ref_leds   = 8'd0;
      ref_err    = 1'b0;
      for (int i = 0; i < 256; i++) begin
         bram_mem[i] = $urandom;
         ref_mem[i]  = bram_mem[i];
      end
      test_reset();
      test_ram_read();
      test_mmio_led();
      test_cycle_counter();
      test_unmapped_status();
      test_timeout();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
